// File: rtl/spi_mult_peripheral_if.sv
// SPI-style bus between a master and the multiplier peripheral.
//   cs        : chip select, active-high; a frame spans cs high
//   sclk      : serial clock from the master, asynchronous to the system clock
//   mosi      : serial data from the master, changed while sclk is low
//   miso      : serial product data, MSB first
//   busy      : high while the multiplier engine runs
//   frame_err : sticky protocol-error flag, cleared on the next cs rise
interface spi_mult_peripheral_if;
  logic cs;
  logic sclk;
  logic mosi;
  logic miso;
  logic busy;
  logic frame_err;

  modport master (output cs, sclk, mosi, input miso, busy, frame_err);
  modport slave  (input cs, sclk, mosi, output miso, busy, frame_err);
endinterface

// File: rtl/spi_mult_peripheral.sv
// SPI multiplier peripheral. Receives a mode bit plus two WIDTH-bit operands
// (MSB first), multiplies them unsigned or two's-complement signed with a
// sequential shift-add engine, and returns the 2*WIDTH-bit product MSB first.
// All logic runs on clk; the SPI pins are synchronised into that domain.
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : slave side of spi_mult_peripheral_if (cs, sclk, mosi in;
//         miso, busy, frame_err out, all outputs registered)
module spi_mult_peripheral #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  rst,
  spi_mult_peripheral_if.slave bus
);
  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(PW + 2);
  localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(PW);       // mode + 2*WIDTH operand bits
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(WIDTH);    // WIDTH iterations, then load
  localparam logic [CNT_W-1:0] TX_LAST  = CNT_W'(PW - 1);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_MUL, S_TX, S_HOLD} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   cs_prev_q, cs_prev_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]          rx_q, rx_d;
  logic [PW-1:0]          acc_q, acc_d;
  logic [PW-1:0]          mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic                   sign_q, sign_d;
  logic [PW-1:0]          shreg_q, shreg_d;
  logic                   miso_q, miso_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;

  logic cs_s, sclk_s, mosi_s;
  logic cs_rise, cs_fall, sclk_rise;
  logic             abort;
  logic [PW:0]      rx_shift;
  logic             frame_mode;
  logic [WIDTH-1:0] frame_a, frame_b, mag_a, mag_b;

  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_prev_d   = cs_s;
  assign sclk_prev_d = sclk_s;
  assign cs_rise     = cs_s & ~cs_prev_q;
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign sclk_rise   = sclk_s & ~sclk_prev_q;

  // The completed frame is decoded from the shifted value so the engine can
  // be loaded on the same edge that captures the last B bit; the mode bit
  // falls off the top of rx_q and is consumed right here.
  assign rx_shift   = {rx_q, mosi_s};
  assign frame_mode = rx_shift[PW];
  assign frame_a    = rx_shift[PW-1:WIDTH];
  assign frame_b    = rx_shift[WIDTH-1:0];
  // Magnitudes stay WIDTH bits unsigned: -2^(WIDTH-1) negates to 2^(WIDTH-1),
  // which still fits, so the most-negative squared case is exact.
  assign mag_a = (frame_mode && frame_a[WIDTH-1]) ? -frame_a : frame_a;
  assign mag_b = (frame_mode && frame_b[WIDTH-1]) ? -frame_b : frame_b;

  assign abort = cs_fall && (state_q == S_RX || state_q == S_MUL || state_q == S_TX);

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    shreg_d  = shreg_q;
    ferr_d   = ferr_q;

    unique case (state_q)
      S_IDLE: if (cs_rise) begin
        state_d = S_RX;
        cnt_d   = '0;
        rx_d    = '0;
        ferr_d  = 1'b0;
      end
      S_RX: if (sclk_rise) begin
        rx_d = rx_shift[PW-1:0];
        if (cnt_q == RX_LAST) begin
          state_d  = S_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          sign_d   = frame_mode & (frame_a[WIDTH-1] ^ frame_b[WIDTH-1]);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_MUL: begin
        // The master clocked a read before the product was ready.
        if (sclk_rise) ferr_d = 1'b1;
        if (cnt_q == MUL_LAST) begin
          shreg_d = sign_q ? -acc_q : acc_q;
          state_d = S_TX;
          cnt_d   = '0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      S_TX: if (sclk_rise) begin
        if (cnt_q == TX_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          shreg_d = '0;
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: if (cs_fall) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      rx_d     = '0;
      acc_d    = '0;
      mcand_d  = '0;
      mplier_d = '0;
      sign_d   = 1'b0;
      shreg_d  = '0;
      ferr_d   = 1'b1;
    end

    busy_d = (state_d == S_MUL);
    miso_d = (state_d == S_TX) ? shreg_d[PW-1] : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      cnt_q       <= '0;
      rx_q        <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      sign_q      <= 1'b0;
      shreg_q     <= '0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      sign_q      <= sign_d;
      shreg_q     <= shreg_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      ferr_q      <= ferr_d;
    end
  end

  assign bus.miso      = miso_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_spi_mult_peripheral.sv
// Directed bench for spi_mult_peripheral: one WIDTH=4 and one WIDTH=8
// instance sharing clk/rst, each driven by its own SPI master model.
module tb_spi_mult_peripheral;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cs_v   = '0;
  logic [1:0] sclk_v = '0;
  logic [1:0] mosi_v = '0;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  spi_mult_peripheral_if bus4 ();
  spi_mult_peripheral_if bus8 ();

  assign bus4.cs   = cs_v[0];
  assign bus4.sclk = sclk_v[0];
  assign bus4.mosi = mosi_v[0];
  assign bus8.cs   = cs_v[1];
  assign bus8.sclk = sclk_v[1];
  assign bus8.mosi = mosi_v[1];

  spi_mult_peripheral #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  spi_mult_peripheral #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  function automatic logic get_miso(input int sel);
    return (sel == 1) ? bus8.miso : bus4.miso;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 1) ? bus8.busy : bus4.busy;
  endfunction
  function automatic logic get_ferr(input int sel);
    return (sel == 1) ? bus8.frame_err : bus4.frame_err;
  endfunction

  // Frame bit i: 0 = mode, then A MSB first, then B MSB first.
  function automatic logic frame_bit(input int w, input int i, input logic mode,
                                     input logic [7:0] a, input logic [7:0] b);
    if (i == 0) return mode;
    if (i <= w) return a[w-i];
    return b[2*w-i];
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int sel, input logic b);
    mosi_v[sel] = b;
    clk_wait(8);
    sclk_v[sel] = 1'b1;
    clk_wait(8);
    sclk_v[sel] = 1'b0;
  endtask

  // Full frame: write, time BUSY, read the product, check HOLD and error flag.
  // With glitch set, a premature read rise is issued while the engine runs.
  task automatic run_frame(input int sel, input int w, input logic mode,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_p, input logic glitch,
                           input logic exp_ferr, input string name);
    int          busy_cnt;
    logic [15:0] r;
    cs_v[sel] = 1'b1;
    clk_wait(8);
    check({name, "_ferr_clr"}, 32'(get_ferr(sel)), 32'd0);
    for (int i = 0; i < 2*w; i++) send_bit(sel, frame_bit(w, i, mode, a, b));
    mosi_v[sel] = frame_bit(w, 2*w, mode, a, b);
    clk_wait(8);
    sclk_v[sel] = 1'b1;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (get_busy(sel)) busy_cnt++;
      if (glitch && i == 4) sclk_v[sel] = 1'b0;
      if (glitch && i == 6) sclk_v[sel] = 1'b1;
    end
    sclk_v[sel] = 1'b0;
    check({name, "_busy_len"}, 32'(busy_cnt), 32'(w + 1));
    r = '0;
    for (int k = 0; k < 2*w; k++) begin
      clk_wait(8);
      r = {r[14:0], get_miso(sel)};
      sclk_v[sel] = 1'b1;
      clk_wait(8);
      sclk_v[sel] = 1'b0;
    end
    check({name, "_product"}, 32'(r), 32'(exp_p));
    clk_wait(8);
    check({name, "_hold_miso"}, 32'(get_miso(sel)), 32'd0);
    check({name, "_ferr_end"}, 32'(get_ferr(sel)), 32'(exp_ferr));
    cs_v[sel] = 1'b0;
    clk_wait(8);
  endtask

  initial begin
    clk_wait(3);
    check("rst_miso4", 32'(bus4.miso), 32'd0);
    check("rst_busy4", 32'(bus4.busy), 32'd0);
    check("rst_ferr4", 32'(bus4.frame_err), 32'd0);
    check("rst_miso8", 32'(bus8.miso), 32'd0);
    check("rst_busy8", 32'(bus8.busy), 32'd0);
    check("rst_ferr8", 32'(bus8.frame_err), 32'd0);
    rst = 1'b0;
    clk_wait(4);

    // WIDTH=4 unsigned and signed corners.
    run_frame(0, 4, 1'b0, 8'h1, 8'h6, 16'h0006, 1'b0, 1'b0, "u_1x6");
    run_frame(0, 4, 1'b0, 8'hF, 8'hF, 16'h00E1, 1'b0, 1'b0, "u_15x15");
    run_frame(0, 4, 1'b1, 8'hD, 8'h5, 16'h00F1, 1'b0, 1'b0, "s_m3x5");
    run_frame(0, 4, 1'b1, 8'h8, 8'h8, 16'h0040, 1'b0, 1'b0, "s_m8xm8");
    run_frame(0, 4, 1'b1, 8'h7, 8'h8, 16'h00C8, 1'b0, 1'b0, "s_7xm8");

    // WIDTH=8.
    run_frame(1, 8, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, "w8_ffxff");

    // Abort after three B bits.
    cs_v[0] = 1'b1;
    clk_wait(8);
    for (int i = 0; i < 8; i++) send_bit(0, frame_bit(4, i, 1'b0, 8'h1, 8'h6));
    cs_v[0] = 1'b0;
    clk_wait(8);
    check("abort_miso", 32'(bus4.miso), 32'd0);
    check("abort_ferr", 32'(bus4.frame_err), 32'd1);
    check("abort_busy", 32'(bus4.busy), 32'd0);
    run_frame(0, 4, 1'b0, 8'h1, 8'h6, 16'h0006, 1'b0, 1'b0, "post_abort");

    // Premature read rise while the engine runs; product still delivered.
    run_frame(1, 8, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b1, "mul_sclk");
    run_frame(1, 8, 1'b1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, "w8_m128sq");

    // Reset in the middle of MUL.
    cs_v[0] = 1'b1;
    clk_wait(8);
    for (int i = 0; i < 8; i++) send_bit(0, frame_bit(4, i, 1'b1, 8'hD, 8'h5));
    mosi_v[0] = frame_bit(4, 8, 1'b1, 8'hD, 8'h5);
    clk_wait(8);
    sclk_v[0] = 1'b1;
    clk_wait(5);
    check("mid_mul_busy", 32'(bus4.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mul_busy", 32'(bus4.busy), 32'd0);
    check("rst_mul_miso", 32'(bus4.miso), 32'd0);
    check("rst_mul_ferr", 32'(bus4.frame_err), 32'd0);
    cs_v[0]   = 1'b0;
    sclk_v[0] = 1'b0;
    mosi_v[0] = 1'b0;
    clk_wait(4);
    rst = 1'b0;
    clk_wait(4);
    run_frame(0, 4, 1'b1, 8'hD, 8'h5, 16'h00F1, 1'b0, 1'b0, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
